// File: rtl/tcp_msg_poller_sched.sv
// tcp_msg_poller_sched: round-robin scheduler that turns satisfied TCP poll requests into notifications
`ifndef MSG_SRC_X_WIDTH
`define MSG_SRC_X_WIDTH 8
`endif
`ifndef MSG_SRC_Y_WIDTH
`define MSG_SRC_Y_WIDTH 8
`endif
`ifndef NOC_FBITS_WIDTH
`define NOC_FBITS_WIDTH 4
`endif
module tcp_msg_poller_sched #(
    parameter int MAX_FLOW_CNT = 64,
    parameter int FLOWID_W = 6,
    parameter int POLLER_PTR_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MAX_FLOW_CNT-1:0]     active_bitvec,
    output logic                        sched_active_bitvec_clear_val,
    output logic [FLOWID_W-1:0]         sched_active_bitvec_clear_flowid,
    output logic                        sched_msg_req_mem_rd_val,
    output logic [FLOWID_W-1:0]         sched_msg_req_mem_rd_addr,
    input  logic                        msg_req_mem_sched_rd_rdy,
    input  logic                        msg_req_mem_sched_rd_resp_val,
    input  logic [POLLER_PTR_W-1:0]     msg_req_mem_sched_rd_resp_len,
    input  logic [`MSG_SRC_X_WIDTH-1:0] msg_req_mem_sched_rd_resp_dst_x,
    input  logic [`MSG_SRC_Y_WIDTH-1:0] msg_req_mem_sched_rd_resp_dst_y,
    input  logic [`NOC_FBITS_WIDTH-1:0] msg_req_mem_sched_rd_resp_dst_fbits,
    output logic                        sched_ptr_mem_rd_req_val,
    output logic [FLOWID_W-1:0]         sched_ptr_mem_rd_req_flowid,
    input  logic                        ptr_mem_sched_rd_req_rdy,
    input  logic                        ptr_mem_sched_rd_resp_val,
    input  logic [POLLER_PTR_W-1:0]     ptr_mem_sched_rd_resp_head,
    input  logic [POLLER_PTR_W-1:0]     ptr_mem_sched_rd_resp_commit,
    output logic                        sched_notif_val,
    output logic [FLOWID_W-1:0]         sched_notif_flowid,
    output logic [POLLER_PTR_W-1:0]     sched_notif_len,
    output logic [`MSG_SRC_X_WIDTH-1:0] sched_notif_dst_x,
    output logic [`MSG_SRC_Y_WIDTH-1:0] sched_notif_dst_y,
    output logic [`NOC_FBITS_WIDTH-1:0] sched_notif_dst_fbits,
    input  logic                        notif_sched_rdy
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD_REQ = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] CHECK  = 3'd3;
    localparam logic [2:0] NOTIF  = 3'd4;

    logic [2:0]              state;
    logic [FLOWID_W-1:0]     rr_ptr, cur_flowid, pick_flowid;
    logic [MAX_FLOW_CNT-1:0] rot;
    logic                    req_acc, ptr_acc, req_cap, ptr_cap;
    logic                    req_hs, ptr_hs, req_resp, ptr_resp, notif_hs, in_rd, ready;
    logic [POLLER_PTR_W-1:0] req_len, head, commit, avail, notif_len;
    logic [`MSG_SRC_X_WIDTH-1:0] dst_x;
    logic [`MSG_SRC_Y_WIDTH-1:0] dst_y;
    logic [`NOC_FBITS_WIDTH-1:0] dst_fbits;

    assign in_rd    = (state == RD_REQ) || (state == WAIT);
    assign req_hs   = sched_msg_req_mem_rd_val & msg_req_mem_sched_rd_rdy;
    assign ptr_hs   = sched_ptr_mem_rd_req_val & ptr_mem_sched_rd_req_rdy;
    assign req_resp = in_rd & req_acc & ~req_cap & msg_req_mem_sched_rd_resp_val;
    assign ptr_resp = in_rd & ptr_acc & ~ptr_cap & ptr_mem_sched_rd_resp_val;
    assign notif_hs = sched_notif_val & notif_sched_rdy;
    assign avail    = commit - head;
    assign ready    = (req_len == '0) ? (avail != '0) : (avail >= req_len);

    assign sched_msg_req_mem_rd_val         = (state == RD_REQ) & ~req_acc;
    assign sched_msg_req_mem_rd_addr        = cur_flowid;
    assign sched_ptr_mem_rd_req_val         = (state == RD_REQ) & ~ptr_acc;
    assign sched_ptr_mem_rd_req_flowid      = cur_flowid;
    assign sched_notif_val                  = state == NOTIF;
    assign sched_notif_flowid               = cur_flowid;
    assign sched_notif_len                  = notif_len;
    assign sched_notif_dst_x                = dst_x;
    assign sched_notif_dst_y                = dst_y;
    assign sched_notif_dst_fbits            = dst_fbits;
    assign sched_active_bitvec_clear_val    = notif_hs;
    assign sched_active_bitvec_clear_flowid = cur_flowid;

    // rotate the bitvector so rr_ptr lands on bit 0, then take the lowest set bit
    always_comb begin
        rot = MAX_FLOW_CNT'({active_bitvec, active_bitvec} >> rr_ptr);
        pick_flowid = rr_ptr;
        for (int i = MAX_FLOW_CNT - 1; i >= 0; i--)
            if (rot[i]) pick_flowid = rr_ptr + FLOWID_W'(i);
    end

    // control FSM: select, issue both reads, collect both responses, decide, notify
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cur_flowid <= '0;
            req_acc    <= 1'b0;
            ptr_acc    <= 1'b0;
            req_cap    <= 1'b0;
            ptr_cap    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|active_bitvec) begin
                    cur_flowid <= pick_flowid;
                    req_acc    <= 1'b0;
                    ptr_acc    <= 1'b0;
                    req_cap    <= 1'b0;
                    ptr_cap    <= 1'b0;
                    state      <= RD_REQ;
                end
                RD_REQ: begin
                    if (req_hs) req_acc <= 1'b1;
                    if (ptr_hs) ptr_acc <= 1'b1;
                    if ((req_acc | req_hs) & (ptr_acc | ptr_hs)) state <= WAIT;
                end
                WAIT: if ((req_cap | req_resp) & (ptr_cap | ptr_resp)) state <= CHECK;
                CHECK: begin
                    rr_ptr <= cur_flowid + 1'b1;
                    state  <= (active_bitvec[cur_flowid] & ready) ? NOTIF : IDLE;
                end
                NOTIF: if (notif_hs) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (req_resp) req_cap <= 1'b1;
            if (ptr_resp) ptr_cap <= 1'b1;
        end
    end

    // capture response payloads and freeze the reported length for the notification
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_len   <= '0;
            dst_x     <= '0;
            dst_y     <= '0;
            dst_fbits <= '0;
            head      <= '0;
            commit    <= '0;
            notif_len <= '0;
        end else begin
            if (req_resp) begin
                req_len   <= msg_req_mem_sched_rd_resp_len;
                dst_x     <= msg_req_mem_sched_rd_resp_dst_x;
                dst_y     <= msg_req_mem_sched_rd_resp_dst_y;
                dst_fbits <= msg_req_mem_sched_rd_resp_dst_fbits;
            end
            if (ptr_resp) begin
                head   <= ptr_mem_sched_rd_resp_head;
                commit <= ptr_mem_sched_rd_resp_commit;
            end
            if (state == CHECK) notif_len <= (req_len == '0) ? avail : req_len;
        end
    end
endmodule

// File: tb/tb_tcp_msg_poller_sched.sv
// tb_tcp_msg_poller_sched: directed and randomized check of the poller scheduler against a transaction model
`timescale 1ns/1ps
`ifndef MSG_SRC_X_WIDTH
`define MSG_SRC_X_WIDTH 8
`endif
`ifndef MSG_SRC_Y_WIDTH
`define MSG_SRC_Y_WIDTH 8
`endif
`ifndef NOC_FBITS_WIDTH
`define NOC_FBITS_WIDTH 4
`endif
module tb_tcp_msg_poller_sched;
    localparam int N  = 64;
    localparam int FW = 6;
    localparam int PW = 16;
    localparam int XW = `MSG_SRC_X_WIDTH;
    localparam int YW = `MSG_SRC_Y_WIDTH;
    localparam int BW = `NOC_FBITS_WIDTH;
    localparam int DW = XW + YW + BW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0]  active_bitvec = '0;
    logic          clear_val, req_val, ptr_val, notif_val;
    logic [FW-1:0] clear_flowid, req_addr, ptr_flowid, notif_flowid;
    logic          req_rdy = 1'b0, req_resp_val = 1'b0, ptr_rdy = 1'b0, ptr_resp_val = 1'b0, notif_rdy = 1'b0;
    logic [PW-1:0] req_resp_len = '0, ptr_head = '0, ptr_commit = '0, notif_len;
    logic [XW-1:0] resp_x = '0, notif_x;
    logic [YW-1:0] resp_y = '0, notif_y;
    logic [BW-1:0] resp_fb = '0, notif_fb;

    always #5 clk = ~clk;

    tcp_msg_poller_sched dut (
        .clk(clk), .rst(rst), .active_bitvec(active_bitvec),
        .sched_active_bitvec_clear_val(clear_val), .sched_active_bitvec_clear_flowid(clear_flowid),
        .sched_msg_req_mem_rd_val(req_val), .sched_msg_req_mem_rd_addr(req_addr),
        .msg_req_mem_sched_rd_rdy(req_rdy), .msg_req_mem_sched_rd_resp_val(req_resp_val),
        .msg_req_mem_sched_rd_resp_len(req_resp_len), .msg_req_mem_sched_rd_resp_dst_x(resp_x),
        .msg_req_mem_sched_rd_resp_dst_y(resp_y), .msg_req_mem_sched_rd_resp_dst_fbits(resp_fb),
        .sched_ptr_mem_rd_req_val(ptr_val), .sched_ptr_mem_rd_req_flowid(ptr_flowid),
        .ptr_mem_sched_rd_req_rdy(ptr_rdy), .ptr_mem_sched_rd_resp_val(ptr_resp_val),
        .ptr_mem_sched_rd_resp_head(ptr_head), .ptr_mem_sched_rd_resp_commit(ptr_commit),
        .sched_notif_val(notif_val), .sched_notif_flowid(notif_flowid), .sched_notif_len(notif_len),
        .sched_notif_dst_x(notif_x), .sched_notif_dst_y(notif_y), .sched_notif_dst_fbits(notif_fb),
        .notif_sched_rdy(notif_rdy)
    );

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // per-flow contents of the request and pointer memories
    logic [PW-1:0] len_m [N];
    logic [PW-1:0] head_m [N];
    logic [PW-1:0] commit_m [N];
    logic [DW-1:0] dst_m [N];

    logic [N-1:0] bv = '0, set_mask = '0, wd_mask = '0, clr_pend = '0, prev_bv = '0;
    logic prev_req_val = 1'b0;
    bit rnd = 0;
    int req_stall = 0, ptr_stall = 0, notif_stall = 0, req_dly = 1, ptr_dly = 1, req_t = 0, ptr_t = 0;
    int s_f = 0;
    logic [PW-1:0] s_len, s_head, s_commit;
    logic [DW-1:0] s_dst;
    int m_rr = 0, e_len = 0;
    bit exp_notif = 0;
    int cyc = 0, n_req = 0, n_notif = 0, n_clear = 0, last_start = 0, last_len = 0, notif_cycles = 0;
    int notif_q[$];

    function automatic int rr_pick(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++)
            if (v[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    function automatic logic [63:0] all_outs();
        return {clear_val, clear_flowid, req_val, req_addr, ptr_val, ptr_flowid,
                notif_val, notif_flowid, notif_len, notif_x, notif_y, notif_fb};
    endfunction

    // transaction-level reference: who should be picked and what the notification must carry
    task automatic monitor();
        int a;
        if (req_val && !prev_req_val) begin
            n_req++;
            last_start = cyc;
            check("pick", req_addr, rr_pick(prev_bv, m_rr));
            check("ptr_req", {ptr_val, ptr_flowid}, {1'b1, req_addr});
            check("notif_lost", exp_notif, 1'b0);
            s_f = int'(req_addr);
            s_len = len_m[s_f];
            s_head = head_m[s_f];
            s_commit = commit_m[s_f];
            s_dst = dst_m[s_f];
            a = (int'(s_commit) - int'(s_head) + (1 << PW)) % (1 << PW);
            exp_notif = (s_len == 0) ? (a != 0) : (a >= int'(s_len));
            e_len = (s_len == 0) ? a : int'(s_len);
            m_rr = (s_f + 1) % N;
        end
        if (req_val) begin
            if (req_rdy) req_t = rnd ? int'($urandom_range(1, 4)) : req_dly;
            else if (req_stall > 0) req_stall--;
        end
        if (ptr_val) begin
            check("ptr_flowid_hold", ptr_flowid, s_f);
            if (ptr_rdy) ptr_t = rnd ? int'($urandom_range(1, 4)) : ptr_dly;
            else if (ptr_stall > 0) ptr_stall--;
        end
        if (notif_val) begin
            notif_cycles++;
            check("notif_expected", exp_notif, 1'b1);
            check("notif_flowid", notif_flowid, s_f);
            check("notif_len", notif_len, e_len);
            check("notif_dst", {notif_x, notif_y, notif_fb}, s_dst);
            if (notif_rdy) begin
                check("clear_on_hs", {clear_val, clear_flowid}, {1'b1, FW'(s_f)});
                exp_notif = 0;
                n_notif++;
                last_len = int'(notif_len);
                notif_q.push_back(s_f);
            end else if (notif_stall > 0) notif_stall--;
        end
        if (!(notif_val && notif_rdy)) check("no_stray_clear", clear_val, 1'b0);
        if (clear_val) n_clear++;
        clr_pend = clear_val ? (N'(1) << clear_flowid) : '0;
        prev_bv = bv;
        prev_req_val = req_val;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        bv = ((bv & ~clr_pend) | set_mask) & ~wd_mask;
        set_mask = '0;
        wd_mask = '0;
        active_bitvec = bv;
        req_rdy = (req_stall == 0) && (!rnd || $urandom_range(0, 3) != 0);
        ptr_rdy = (ptr_stall == 0) && (!rnd || $urandom_range(0, 3) != 0);
        notif_rdy = (notif_stall == 0) && (!rnd || $urandom_range(0, 3) != 0);
        req_resp_val = 1'b0;
        ptr_resp_val = 1'b0;
        {req_resp_len, resp_x, resp_y, resp_fb} = rnd ? {PW'($urandom), DW'($urandom)} : '0;
        {ptr_head, ptr_commit} = rnd ? $urandom : '0;
        if (req_t > 0) begin
            req_t--;
            if (req_t == 0) begin
                req_resp_val = 1'b1;
                {req_resp_len, resp_x, resp_y, resp_fb} = {s_len, s_dst};
            end
        end
        if (ptr_t > 0) begin
            ptr_t--;
            if (ptr_t == 0) begin
                ptr_resp_val = 1'b1;
                {ptr_head, ptr_commit} = {s_head, s_commit};
            end
        end
        #1;
        monitor();
    endtask

    task automatic wait_notifs(input int target, input int budget, input string tag);
        int k = 0;
        while (n_notif < target && k < budget) begin
            step();
            k++;
        end
        check(tag, n_notif, target);
    endtask

    task automatic wait_start(input int budget, input string tag);
        int r0 = n_req;
        int k = 0;
        while (n_req == r0 && k < budget) begin
            step();
            k++;
        end
        check(tag, n_req != r0, 1'b1);
    endtask

    task automatic set_flow(input int f, input int l, input int h, input int c);
        len_m[f] = PW'(l);
        head_m[f] = PW'(h);
        commit_m[f] = PW'(c);
        dst_m[f] = DW'($urandom);
        set_mask[f] = 1'b1;
    endtask

    initial begin
        int c0, k, n0, r0, f;
        for (int i = 0; i < N; i++) begin
            len_m[i] = '0;
            head_m[i] = '0;
            commit_m[i] = '0;
            dst_m[i] = '0;
        end
        step();
        step();
        check("reset_outputs", all_outs(), 64'd0);
        rst = 1'b1;
        step();
        check("idle_outputs", all_outs(), 64'd0);

        // single flow, minimum latency
        set_flow(5, 100, 16'h0010, 16'h0080);
        step();
        c0 = cyc;
        k = 0;
        while (!notif_val && k < 20) begin
            step();
            k++;
        end
        check("t1_latency", cyc - c0, 4);
        check("t1_len", notif_len, 100);
        step();
        check("t1_bit_cleared", bv[5], 1'b0);
        check("t1_clear_count", n_clear, 1);

        // three flows from rr_ptr 6, then wrap back to 0
        notif_q.delete();
        set_flow(2, 8, 0, 100);
        set_flow(9, 8, 0, 100);
        set_flow(63, 8, 0, 100);
        wait_notifs(4, 60, "t2_three_notifs");
        check("t2_order0", notif_q[0], 9);
        check("t2_order1", notif_q[1], 63);
        check("t2_order2", notif_q[2], 2);
        set_flow(63, 1, 0, 1);
        wait_notifs(5, 30, "t2_flow63");
        notif_q.delete();
        set_flow(9, 8, 0, 100);
        set_flow(2, 8, 0, 100);
        wait_notifs(7, 60, "t2_wrap_pair");
        check("t2_wrap_first", notif_q[0], 2);
        r0 = n_req;
        repeat (10) step();
        check("t2_idle", n_req, r0);

        // unsatisfied across pointer wrap, then satisfied
        n0 = n_notif;
        set_flow(3, 200, 16'hFFF0, 16'h0040);
        wait_start(20, "t3_start");
        repeat (6) step();
        check("t3_no_notif", n_notif, n0);
        check("t3_still_active", bv[3], 1'b1);
        commit_m[3] = 16'h00D8;
        wait_notifs(n0 + 1, 100, "t3_notif");
        check("t3_len", last_len, 200);

        // zero-length request waits for any data
        n0 = n_notif;
        set_flow(7, 0, 16'h1234, 16'h1234);
        wait_start(20, "t4_start");
        repeat (6) step();
        check("t4_no_notif", n_notif, n0);
        commit_m[7] = 16'h1245;
        wait_notifs(n0 + 1, 100, "t4_notif");
        check("t4_len", last_len, 17);

        // out-of-order responses, read stall, notification backpressure
        n0 = n_notif;
        c0 = n_clear;
        notif_cycles = 0;
        req_stall = 2;
        req_dly = 2;
        notif_stall = 5;
        set_flow(11, 50, 0, 100);
        wait_notifs(n0 + 1, 40, "t5_notif");
        repeat (8) step();
        check("t5_one_notif", n_notif, n0 + 1);
        check("t5_one_clear", n_clear, c0 + 1);
        check("t5_notif_cycles", notif_cycles, 6);
        req_dly = 1;

        // active bit withdrawn before the decision
        n0 = n_notif;
        c0 = n_clear;
        ptr_dly = 3;
        set_flow(4, 10, 0, 50);
        wait_start(20, "wd_start");
        wd_mask[4] = 1'b1;
        exp_notif = 0;
        repeat (10) step();
        check("wd_no_notif", n_notif, n0);
        check("wd_no_clear", n_clear, c0);
        ptr_dly = 1;
        notif_q.delete();
        set_flow(2, 1, 0, 5);
        set_flow(6, 1, 0, 5);
        wait_notifs(n0 + 2, 60, "wd_after");
        check("wd_rr_next", notif_q[0], 6);

        // reset while waiting for a response, then a stale response
        ptr_dly = 4;
        set_flow(12, 1, 0, 5);
        wait_start(20, "rst_start");
        repeat (2) step();
        rst = 1'b0;
        wd_mask = '1;
        m_rr = 0;
        exp_notif = 0;
        clr_pend = '0;
        step();
        check("rst_wait_outputs", all_outs(), 64'd0);
        rst = 1'b1;
        n0 = n_notif;
        r0 = n_req;
        repeat (10) step();
        check("rst_stale_no_req", n_req, r0);
        check("rst_stale_no_notif", n_notif, n0);
        ptr_dly = 1;
        set_flow(12, 1, 0, 5);
        wait_notifs(n0 + 1, 40, "rst_recover");

        // randomized traffic
        n0 = n_notif;
        rnd = 1;
        last_start = cyc;
        for (int t = 0; t < 6000; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                f = int'($urandom_range(0, N - 1));
                k = int'($urandom);
                set_flow(f, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 3000)), k,
                         ($urandom_range(0, 3) == 0) ? k : k + int'($urandom_range(0, 4000)));
            end
            if ($urandom_range(0, 7) == 0) begin
                f = int'($urandom_range(0, N - 1));
                commit_m[f] = commit_m[f] + PW'($urandom_range(0, 500));
            end
            step();
            if (t % 50 == 0 && bv != '0) check("rand_progress", (cyc - last_start) <= 80, 1'b1);
        end
        rnd = 0;
        check("rand_notifs", n_notif > n0 + 100, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
